// File: rtl/hazard_controller.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Keeps shadow EX/MEM/WB destination state, drives the forwarding selects, the stalls and the branch flush.
module hazard_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rsD,
    input  logic [REG_AW-1:0] rtD,
    input  logic              useRsD,
    input  logic              useRtD,
    input  logic [REG_AW-1:0] writeRegD,
    input  logic              regWriteD,
    input  logic              mem2RegD,
    input  logic              branchD,
    input  logic              pcSrcD,
    output logic [1:0]        fad,
    output logic [1:0]        fbd,
    output logic              stallF,
    output logic              stallD,
    output logic              flushE,
    output logic              flush,
    output logic [CNT_W-1:0]  stallCount
);

    logic [REG_AW-1:0] rs_e, rt_e, write_reg_e;
    logic              reg_write_e, mem2reg_e;
    logic [REG_AW-1:0] write_reg_m;
    logic              reg_write_m, mem2reg_m;
    logic [REG_AW-1:0] write_reg_w;
    logic              reg_write_w;
    logic              lw_stall, br_stall, stall;
    logic              rs_used, rt_used;

    always_comb begin
        fad = 2'd0;
        if (rs_e != '0 && reg_write_m && write_reg_m == rs_e)
            fad = 2'd2;
        else if (rs_e != '0 && reg_write_w && write_reg_w == rs_e)
            fad = 2'd1;

        fbd = 2'd0;
        if (rt_e != '0 && reg_write_m && write_reg_m == rt_e)
            fbd = 2'd2;
        else if (rt_e != '0 && reg_write_w && write_reg_w == rt_e)
            fbd = 2'd1;
    end

    // Register 0 is excluded by qualifying each operand once here.
    assign rs_used = useRsD && rsD != '0;
    assign rt_used = useRtD && rtD != '0;

    assign lw_stall = mem2reg_e && write_reg_e != '0 &&
                      ((useRsD && rsD == write_reg_e) || (useRtD && rtD == write_reg_e));

    assign br_stall = branchD && (
                      (rs_used && reg_write_e && write_reg_e == rsD) ||
                      (rt_used && reg_write_e && write_reg_e == rtD) ||
                      (rs_used && mem2reg_m && write_reg_m == rsD) ||
                      (rt_used && mem2reg_m && write_reg_m == rtD));

    assign stall  = lw_stall | br_stall;
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;
    assign flush  = pcSrcD && branchD && !stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rs_e        <= '0;
            rt_e        <= '0;
            write_reg_e <= '0;
            reg_write_e <= 1'b0;
            mem2reg_e   <= 1'b0;
            write_reg_m <= '0;
            reg_write_m <= 1'b0;
            mem2reg_m   <= 1'b0;
            write_reg_w <= '0;
            reg_write_w <= 1'b0;
            stallCount  <= '0;
        end else begin
            if (stall) begin
                rs_e        <= '0;
                rt_e        <= '0;
                write_reg_e <= '0;
                reg_write_e <= 1'b0;
                mem2reg_e   <= 1'b0;
            end else begin
                rs_e        <= rsD;
                rt_e        <= rtD;
                write_reg_e <= writeRegD;
                reg_write_e <= regWriteD;
                mem2reg_e   <= mem2RegD;
            end
            write_reg_m <= write_reg_e;
            reg_write_m <= reg_write_e;
            mem2reg_m   <= mem2reg_e;
            write_reg_w <= write_reg_m;
            reg_write_w <= reg_write_m;
            if (stall && stallCount != '1)
                stallCount <= stallCount + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: an instruction-level pipeline model checked every cycle,
// plus literal expectations for each scenario; a second instance with a 3-bit counter checks saturation.
module tb_hazard_controller;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rsD, rtD, writeRegD;
    logic          useRsD, useRtD, regWriteD, mem2RegD, branchD, pcSrcD;

    logic [1:0]  fad, fbd, fad_s, fbd_s;
    logic        stallF, stallD, flushE, flush;
    logic        stallF_s, stallD_s, flushE_s, flush_s;
    logic [15:0] stallCount;
    logic [2:0]  stallCount_s;

    int errors = 0;
    int checks = 0;

    hazard_controller #(.REG_AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .writeRegD(writeRegD), .regWriteD(regWriteD), .mem2RegD(mem2RegD),
        .branchD(branchD), .pcSrcD(pcSrcD), .fad(fad), .fbd(fbd), .stallF(stallF),
        .stallD(stallD), .flushE(flushE), .flush(flush), .stallCount(stallCount)
    );

    hazard_controller #(.REG_AW(AW), .CNT_W(3)) dut_small (
        .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
        .writeRegD(writeRegD), .regWriteD(regWriteD), .mem2RegD(mem2RegD),
        .branchD(branchD), .pcSrcD(pcSrcD), .fad(fad_s), .fbd(fbd_s), .stallF(stallF_s),
        .stallD(stallD_s), .flushE(flushE_s), .flush(flush_s), .stallCount(stallCount_s)
    );

    always #5 clk = ~clk;

    // In-flight instructions: index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic [AW-1:0] wr;
        logic          rw;
        logic          ld;
    } ins_t;

    ins_t pipe [3];
    int   model_cnt = 0;
    bit   model_valid = 0;

    // The nearest older instruction that writes r supplies the operand; MEM is one stage closer than WB.
    function automatic logic [1:0] exp_fwd(logic [AW-1:0] r);
        if (r == '0) return 2'd0;
        for (int s = 1; s <= 2; s++)
            if (pipe[s].rw && pipe[s].wr == r) return 2'(3 - s);
        return 2'd0;
    endfunction

    // A decode operand must wait if its value cannot be obtained in time from any older instruction.
    function automatic bit blocked(logic [AW-1:0] r, logic used, logic br);
        if (!used || r == '0) return 1'b0;
        if (pipe[0].ld && pipe[0].wr == r) return 1'b1;
        if (br && pipe[0].rw && pipe[0].wr == r) return 1'b1;
        if (br && pipe[1].ld && pipe[1].wr == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_stall();
        return blocked(rsD, useRsD, branchD) | blocked(rtD, useRtD, branchD);
    endfunction

    function automatic int sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic st;
        if (rst) begin
            for (int i = 0; i < 3; i++) pipe[i] = '0;
            model_cnt   = 0;
            model_valid = 1;
        end else if (model_valid) begin
            st = exp_stall();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st) begin
                pipe[0] = '0;
                model_cnt++;
            end else begin
                pipe[0] = '{rs: rsD, rt: rtD, wr: writeRegD, rw: regWriteD, ld: mem2RegD};
            end
        end
    end

    always @(negedge clk) begin
        logic st;
        if (model_valid) begin
            st = exp_stall();
            chk("m_fad",    int'(fad),    int'(exp_fwd(pipe[0].rs)));
            chk("m_fbd",    int'(fbd),    int'(exp_fwd(pipe[0].rt)));
            chk("m_stallF", int'(stallF), int'(st));
            chk("m_stallD", int'(stallD), int'(st));
            chk("m_flushE", int'(flushE), int'(st));
            chk("m_flush",  int'(flush),  int'(pcSrcD && branchD && !st));
            chk("m_count",  int'(stallCount), sat(model_cnt, 65535));
            chk("m_count_small", int'(stallCount_s), sat(model_cnt, 7));
            chk("m_stall_small", int'(stallF_s), int'(st));
        end
    end

    task automatic set_d(int rs, int rt, bit urs, bit urt, int wr, bit rw, bit ld, bit br, bit pc);
        rsD = AW'(rs); rtD = AW'(rt); useRsD = urs; useRtD = urt;
        writeRegD = AW'(wr); regWriteD = rw; mem2RegD = ld; branchD = br; pcSrcD = pc;
    endtask

    task automatic nop();
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        nop();
        tick();
        tick();
        rst = 1'b0;
        at_neg();
        chk("rst_fad", int'(fad), 0);
        chk("rst_stall", int'(stallF), 0);
        chk("rst_flush", int'(flush), 0);
        chk("rst_count", int'(stallCount), 0);

        // ALU->ALU forwarding at distance 1 and 2
        set_d(1, 2, 1, 1, 3, 1, 0, 0, 0); tick();
        set_d(3, 0, 1, 0, 8, 1, 0, 0, 0); tick();
        set_d(3, 0, 1, 0, 0, 0, 0, 0, 0);
        at_neg();
        chk("dist1_fad", int'(fad), 2);
        chk("dist1_nostall", int'(stallF), 0);
        tick();
        nop();
        at_neg();
        chk("dist2_fad", int'(fad), 1);

        // Double match favours MEM; register 0 never forwards
        set_d(0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
        set_d(0, 0, 0, 0, 4, 1, 0, 0, 0); tick();
        set_d(0, 4, 0, 1, 0, 0, 0, 0, 0); tick();
        set_d(0, 0, 0, 0, 0, 1, 0, 0, 0);
        at_neg();
        chk("double_fbd", int'(fbd), 2);
        tick();
        set_d(0, 0, 1, 1, 0, 0, 0, 0, 0); tick();
        nop();
        at_neg();
        chk("r0_fad", int'(fad), 0);
        chk("r0_fbd", int'(fbd), 0);
        tick();

        // Load-use: one stall cycle, then WB forwarding
        set_d(0, 0, 0, 0, 5, 1, 1, 0, 0); tick();
        set_d(0, 5, 0, 1, 9, 1, 0, 0, 0);
        at_neg();
        chk("lu_stallF", int'(stallF), 1);
        chk("lu_flushE", int'(flushE), 1);
        chk("lu_count0", int'(stallCount), 0);
        tick();
        at_neg();
        chk("lu_stall_cleared", int'(stallD), 0);
        chk("lu_count1", int'(stallCount), 1);
        tick();
        nop();
        at_neg();
        chk("lu_fbd", int'(fbd), 1);

        // Taken branch without and with an EX dependency
        set_d(1, 2, 1, 1, 0, 0, 0, 1, 1);
        at_neg();
        chk("br_flush", int'(flush), 1);
        chk("br_nostall", int'(stallF), 0);
        tick();
        set_d(0, 0, 0, 0, 6, 1, 0, 0, 0); tick();
        set_d(6, 0, 1, 0, 0, 0, 0, 1, 1);
        at_neg();
        chk("brdep_stall", int'(stallF), 1);
        chk("brdep_noflush", int'(flush), 0);
        tick();
        at_neg();
        chk("brdep_flush", int'(flush), 1);
        chk("brdep_count", int'(stallCount), 2);
        tick();

        // Branch behind a load: two stall cycles
        set_d(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
        set_d(7, 0, 1, 0, 0, 0, 0, 1, 1);
        at_neg();
        chk("brld_stall1", int'(stallF), 1);
        tick();
        at_neg();
        chk("brld_stall2", int'(stallF), 1);
        chk("brld_noflush", int'(flush), 0);
        tick();
        at_neg();
        chk("brld_flush", int'(flush), 1);
        chk("brld_count", int'(stallCount), 4);
        tick();

        // Reset in the middle of a stall
        set_d(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
        set_d(7, 0, 1, 0, 0, 0, 0, 1, 1);
        at_neg();
        chk("rstmid_pre", int'(stallF), 1);
        rst = 1'b1;
        nop();
        tick();
        rst = 1'b0;
        at_neg();
        chk("rstmid_stall", int'(stallF), 0);
        chk("rstmid_flush", int'(flush), 0);
        chk("rstmid_fad", int'(fad), 0);
        chk("rstmid_count", int'(stallCount), 0);

        // Ten stall cycles: five not-taken branches each behind a load
        for (int k = 0; k < 5; k++) begin
            set_d(0, 0, 0, 0, 7, 1, 1, 0, 0); tick();
            set_d(0, 7, 0, 1, 0, 0, 0, 1, 0); tick(); tick(); tick();
        end
        nop();
        at_neg();
        chk("sat_count16", int'(stallCount), 10);
        chk("sat_count3", int'(stallCount_s), 7);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Central hazard and forwarding controller for the 5-stage pipelined datapath.
- Tracks shadow copies of the EX, MEM and WB destination-register state.
- Drives the datapath forwarding selects (fad, fbd) and the IF/ID flush.
- Generates fetch/decode stalls and EX bubbles for load-use and branch-operand hazards, and keeps a saturating stall-cycle counter.

Parameters:
- REG_AW, 5: register address width.
- CNT_W, 16: stall counter width.

Ports:
- clk, input, 1: clock; all state updates on posedge.
- rst, input, 1: synchronous active-high reset.
- rsD, input, REG_AW: decode-stage source register A.
- rtD, input, REG_AW: decode-stage source register B.
- useRsD, input, 1: decode instruction reads rsD.
- useRtD, input, 1: decode instruction reads rtD.
- writeRegD, input, REG_AW: decode destination, already resolved through regDst.
- regWriteD, input, 1: decode instruction writes the register file.
- mem2RegD, input, 1: decode instruction is a load.
- branchD, input, 1: decode instruction is a branch; operands are compared in D.
- pcSrcD, input, 1: branch in D is taken.
- fad, output, 2: EX operand A select; 0 = register file, 1 = WB result, 2 = MEM ALU result; 3 is never driven.
- fbd, output, 2: EX operand B select; same encoding as fad.
- stallF, output, 1: hold PC.
- stallD, output, 1: hold IF/ID.
- flushE, output, 1: insert a bubble into ID/EX.
- flush, output, 1: clear IF/ID (taken branch).
- stallCount, output, CNT_W: number of stall cycles since reset, saturating.

Behaviour:
- **Shadow state:** registers {rsE, rtE, writeRegE, regWriteE, mem2RegE}, {writeRegM, regWriteM, mem2RegM}, {writeRegW, regWriteW}.
  - Each posedge: the EX fields take the D inputs; MEM takes EX; WB takes MEM.
  - When flushE = 1, the EX fields load zero (bubble). MEM and WB always advance.
- **Reset:** all shadow registers and stallCount clear on the posedge with rst = 1.
  - Consequently fad = fbd = 0 and stallF = stallD = flushE = flush = 0 during the following cycle.
  - Reset mid-stall discards the pending hazard.
- **Forwarding (combinational from shadow state):**
  - fad = 2 if rsE != 0 && regWriteM && writeRegM == rsE.
  - Else fad = 1 if rsE != 0 && regWriteW && writeRegW == rsE.
  - Else fad = 0.
  - fbd uses the same rule with rtE. MEM has priority over WB.
- **Load-use hazard:**
  - lwStall = mem2RegE && writeRegE != 0 && ((useRsD && rsD == writeRegE) || (useRtD && rtD == writeRegE)).
- **Branch-operand hazard (branchD = 1, per operand actually used, target register nonzero):**
  - Stall if regWriteE && writeRegE matches the operand.
  - Stall if mem2RegM && writeRegM matches the operand.
  - Call the result brStall.
- **Stall outputs:**
  - stall = lwStall | brStall.
  - stallF = stallD = flushE = stall, all combinational.
  - A stall lasts exactly 1 cycle for a load-use hazard.
  - A branch behind a load in EX lasts 2 cycles: the load goes EX, then MEM.
- **Branch flush:**
  - flush = pcSrcD && branchD && !stall.
  - Stall has priority; a taken branch is re-evaluated once the stall clears.
  - flush is high for exactly the one cycle the branch resolves.
- **Register 0:** never causes a hazard or a forward.
- **stallCount:** +1 on every posedge where stall = 1; holds at all-ones (saturates).
- **Simultaneous lwStall and brStall:** count as one stall cycle.

Test Plan:
1. **ALU→ALU distance 1 and 2:**
   - Stimulus: add to r3 (D), then next cycle a use of rs = r3.
   - Required: fad = 2 in that consumer's EX cycle, no stall.
   - Stimulus: the same producer with the consumer at distance 2.
   - Required: fad = 1.
2. **Double match and r0:**
   - Stimulus: r4 written in both MEM and WB, with rtE = 4.
   - Required: fbd = 2.
   - Stimulus: writes to r0 with rsE = 0.
   - Required: fad = 0 throughout.
3. **Load-use:**
   - Stimulus: lw r5 in EX, decode uses rtD = 5 (useRtD = 1).
   - Required: stallF = stallD = flushE = 1 for exactly 1 cycle, stallCount 0→1.
   - Required: the consumer then sees fbd = 1 in EX.
4. **Taken branch:**
   - Stimulus: branchD = 1, pcSrcD = 1, with no dependencies.
   - Required: flush = 1 for one cycle, stall = 0.
   - Stimulus: the same branch with regWriteE writing its rs.
   - Required: 1 stall cycle, flush = 0, then flush = 1 on the next cycle.
5. **Branch behind load:**
   - Stimulus: lw r7 in EX, branch reading r7 in D.
   - Required: stall for 2 cycles, stallCount +2, then flush = 1 if taken.
6. **Reset and saturation:**
   - Stimulus: assert rst during a stall.
   - Required: all outputs 0 on the following cycle.
   - Stimulus: CNT_W = 3 with a hold of 10 stall cycles.
   - Required: stallCount stops at 7.
